// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: sequences clock_div's divide value N toward a requested target with a settle wait after each step.
// Define CLK_DIV_CTRL_RAMP_EN for a +/-1 ramp; otherwise each change is one direct jump to the target.
`ifndef CLK_DIV
`define CLK_DIV 2
`endif

module clock_div_ctrl #(
    parameter int SIZE       = 3,
    parameter int CNT_W      = 8,
    parameter int SETTLE_CYC = 64
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [SIZE-1:0] req_n,
    input  logic            hold,
    output logic [SIZE-1:0] div_n,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, STEP, SETTLE, DONE} state_t;

    localparam logic [SIZE-1:0]  RST_DIV   = SIZE'(`CLK_DIV);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    state_t            state, state_nx;
    logic [SIZE-1:0]   target, target_nx, div_nx, step_n;
    logic [CNT_W-1:0]  cnt, cnt_nx;

`ifdef CLK_DIV_CTRL_RAMP_EN
    assign step_n = (div_n < target) ? div_n + SIZE'(1) : div_n - SIZE'(1);
`else
    assign step_n = target;
`endif

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state  <= IDLE;
            div_n  <= RST_DIV;
            target <= RST_DIV;
            cnt    <= '0;
        end else begin
            state  <= state_nx;
            div_n  <= div_nx;
            target <= target_nx;
            cnt    <= cnt_nx;
        end
    end

    // hold only stalls STEP; a step already applied always finishes its settle
    always_comb begin
        state_nx  = state;
        div_nx    = div_n;
        target_nx = target;
        cnt_nx    = cnt;
        case (state)
            IDLE: if (req_valid) begin
                target_nx = req_n;
                state_nx  = STEP;
            end
            STEP: if (!hold) begin
                if (div_n == target) state_nx = DONE;
                else begin
                    div_nx   = step_n;
                    cnt_nx   = SETTLE_LD;
                    state_nx = SETTLE;
                end
            end
            SETTLE: if (cnt == '0) state_nx = STEP;
                    else cnt_nx = cnt - CNT_W'(1);
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        done      = (state == DONE);
    end
endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb_clock_div_ctrl: randomized and directed checks of clock_div_ctrl against a step-schedule model.
`ifndef CLK_DIV
`define CLK_DIV 2
`endif

module tb_clock_div_ctrl;
    localparam int S = 4;
`ifdef CLK_DIV_CTRL_RAMP_EN
    localparam int RAMP = 1;
`else
    localparam int RAMP = 0;
`endif
    localparam logic [2:0] RV = 3'(`CLK_DIV);

    logic       clk = 0, resetb = 0, req_valid = 0, hold = 0;
    logic [2:0] req_n = '0;
    logic       req_ready, busy, done;
    logic [2:0] div_n;

    int total = 0, bad = 0;
    // model: m_phase 0 idle, 1 ramping, 2 done cycle; m_next is the earliest edge allowed to step
    logic [2:0] m_div, m_tgt;
    int m_phase, m_next, ecount = 0;

    clock_div_ctrl #(.SIZE(3), .CNT_W(8), .SETTLE_CYC(S)) dut (
        .clk(clk), .resetb(resetb), .req_valid(req_valid), .req_ready(req_ready),
        .req_n(req_n), .hold(hold), .div_n(div_n), .busy(busy), .done(done));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [5:0] obs();
        return {div_n, req_ready, busy, done};
    endfunction

    function automatic logic [5:0] expv();
        return {m_div, m_phase == 0, m_phase != 0, m_phase == 2};
    endfunction

    function automatic int lat(input logic [2:0] from, input logic [2:0] to);
        int k;
        k = (to > from) ? int'(to) - int'(from) : int'(from) - int'(to);
        if (!RAMP && k != 0) k = 1;
        return 1 + k * (S + 1);
    endfunction

    task automatic m_reset();
        m_div = RV; m_tgt = RV; m_phase = 0; m_next = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        ecount++;
        if (m_phase == 2) m_phase = 0;
        else if (m_phase == 0) begin
            if (req_valid) begin m_tgt = req_n; m_phase = 1; m_next = ecount + 1; end
        end else if (ecount >= m_next && !hold) begin
            if (m_div == m_tgt) m_phase = 2;
            else begin
                m_div  = RAMP ? ((m_div < m_tgt) ? m_div + 3'd1 : m_div - 3'd1) : m_tgt;
                m_next = ecount + S + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        resetb = 0; req_valid = 0; hold = 0; m_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL reset got=%h exp=%h", obs(), expv()); end
        resetb = 1;
        tick();
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs(), expv()); end
    endtask

    task automatic test_same_value();
        int acc, de = -1;
        logic [2:0] from = m_div;
        req_n = RV; req_valid = 1; tick(); acc = ecount; req_valid = 0;
        for (int c = 0; c < 50; c++) begin
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL same_value cyc=%0d got=%h exp=%h", c, obs(), expv()); end
            if (done && de < 0) de = ecount;
            if (m_phase == 0) break;
            tick();
        end
        total++;
        if (de - acc != lat(from, RV)) begin bad++; $display("FAIL same_value_latency got=%0d exp=%0d", de - acc, lat(from, RV)); end
    endtask

    task automatic test_ramp_up();
        int acc, de = -1;
        logic [2:0] from = m_div;
        req_n = 3'd5; req_valid = 1; tick(); acc = ecount; req_valid = 0;
        for (int c = 0; c < 200; c++) begin
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL ramp_up cyc=%0d got=%h exp=%h", c, obs(), expv()); end
            if (done && de < 0) de = ecount;
            if (m_phase == 0) break;
            tick();
        end
        total++;
        if (de - acc != lat(from, 3'd5)) begin bad++; $display("FAIL ramp_up_latency got=%0d exp=%0d", de - acc, lat(from, 3'd5)); end
        total++;
        if (div_n !== 3'd5) begin bad++; $display("FAIL ramp_up_final got=%0d exp=5", div_n); end
    endtask

    task automatic test_ramp_down_hold();
        req_n = 3'd1; req_valid = 1; tick(); req_valid = 0;
        tick();
        hold = 1;
        for (int c = 0; c < 3 * S + 6; c++) begin
            if (c == 2) begin req_valid = 1; req_n = 3'd6; end
            if (c == 5) req_valid = 0;
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL hold cyc=%0d got=%h exp=%h", c, obs(), expv()); end
        end
        total++;
        if (div_n !== (RAMP ? 3'd4 : 3'd1) || !busy) begin bad++; $display("FAIL hold_frozen got=%0d busy=%0b exp=%0d", div_n, busy, RAMP ? 4 : 1); end
        hold = 0;
        for (int c = 0; c < 200 && m_phase != 0; c++) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL hold_resume cyc=%0d got=%h exp=%h", c, obs(), expv()); end
        end
        total++;
        if (div_n !== 3'd1 || !req_ready) begin bad++; $display("FAIL hold_final got=%0d ready=%0b exp=1", div_n, req_ready); end
    endtask

    task automatic test_reset_mid_ramp();
        int dones = 0;
        req_n = 3'd7; req_valid = 1; tick(); req_valid = 0;
        repeat (2 * (S + 1) + 1) begin
            tick();
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL pre_reset got=%h exp=%h", obs(), expv()); end
        end
        total++;
        if (div_n !== (RAMP ? 3'd4 : 3'd7)) begin bad++; $display("FAIL mid_ramp_point got=%0d exp=%0d", div_n, RAMP ? 4 : 7); end
        resetb = 0; m_reset();
        #2;
        total++;
        if (obs() !== expv()) begin bad++; $display("FAIL async_reset got=%h exp=%h", obs(), expv()); end
        resetb = 1;
        repeat (10) begin
            tick();
            if (done) dones++;
            total++;
            if (obs() !== expv()) begin bad++; $display("FAIL post_reset got=%h exp=%h", obs(), expv()); end
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL post_reset_done got=%0d exp=0", dones); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            logic [2:0] n, from;
            int hm, acc, de;
            n = 3'($urandom_range(0, 7)); hm = $urandom_range(0, 1);
            from = m_div; de = -1;
            req_n = n; req_valid = 1; tick(); acc = ecount; req_valid = 0;
            for (int c = 0; c < 400; c++) begin
                total++;
                if (obs() !== expv()) begin bad++; $display("FAIL random r=%0d cyc=%0d got=%h exp=%h", r, c, obs(), expv()); end
                if (done && de < 0) de = ecount;
                if (m_phase == 0) break;
                hold = hm ? ($urandom_range(0, 3) == 0) : 1'b0;
                req_valid = ($urandom_range(0, 7) == 0);
                req_n = 3'($urandom_range(0, 7));
                tick();
            end
            req_valid = 0; hold = 0;
            total++;
            if (div_n !== n) begin bad++; $display("FAIL random_final r=%0d got=%0d exp=%0d", r, div_n, n); end
            if (!hm) begin
                total++;
                if (de - acc != lat(from, n)) begin bad++; $display("FAIL random_latency r=%0d got=%0d exp=%0d", r, de - acc, lat(from, n)); end
            end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_same_value();
        test_ramp_up();
        test_ramp_down_hold();
        test_reset_mid_ramp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
